// File: rtl/aemb_intc.sv
// Wishbone-mapped interrupt controller: synchronises NCH interrupt sources, latches them
// per-channel in edge or level mode and raises one masked request plus a priority vector.
module aemb_intc #(
    parameter int NCH = 8,
    parameter int DW  = 32
) (
    input  logic           sys_clk_i,
    input  logic           sys_rst_i,
    input  logic [NCH-1:0] irq_i,
    input  logic           dwb_stb_i,
    input  logic           dwb_wre_i,
    input  logic [2:0]     dwb_adr_i,
    input  logic [DW-1:0]  dwb_dat_i,
    output logic [DW-1:0]  dwb_dat_o,
    output logic           dwb_ack_o,
    output logic           sys_int_o
);

    logic [NCH-1:0] syncA, syncB, edgeHist;
    logic [NCH-1:0] isr, ier, imr;
    logic           mer;

    logic           accept, wrEn;
    logic [NCH-1:0] wrData, isrClr, riseEvt, active;
    logic [NCH-1:0] isrNext, ierNext, imrNext;
    logic           merNext;
    logic [DW-1:0]  ivr, readMux;
    logic           unusedDat;

    assign unusedDat = ^dwb_dat_i;
    assign accept    = dwb_stb_i & ~dwb_ack_o;
    assign wrEn      = accept & dwb_wre_i;
    assign wrData    = dwb_dat_i[NCH-1:0];
    assign riseEvt   = syncB & ~edgeHist;
    assign active    = isr & ier;

    // A write lands on the edge where ack rises; in edge mode a fresh rise beats a clear.
    always_comb begin
        isrClr  = '0;
        ierNext = ier;
        imrNext = imr;
        merNext = mer;
        if (wrEn) begin
            case (dwb_adr_i)
                3'd0, 3'd2: isrClr  = wrData;
                3'd1:       ierNext = wrData;
                3'd3:       ierNext = ier | wrData;
                3'd4:       ierNext = ier & ~wrData;
                3'd6:       merNext = dwb_dat_i[0];
                3'd7:       imrNext = wrData;
                default:    ;
            endcase
        end
        isrNext = (imr & ((isr & ~isrClr) | riseEvt)) | (~imr & syncB);
    end

    // Lowest-numbered active channel wins; all ones when nothing is active.
    always_comb begin
        ivr = '1;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (active[i]) ivr = DW'(i);
        end
    end

    always_comb begin
        readMux = '0;
        case (dwb_adr_i)
            3'd0:    readMux = DW'(isr);
            3'd1:    readMux = DW'(ier);
            3'd5:    readMux = ivr;
            3'd6:    readMux = DW'(mer);
            3'd7:    readMux = DW'(imr);
            default: readMux = '0;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            syncA     <= '0;
            syncB     <= '0;
            edgeHist  <= '0;
            isr       <= '0;
            ier       <= '0;
            imr       <= '0;
            mer       <= 1'b0;
            dwb_ack_o <= 1'b0;
            dwb_dat_o <= '0;
            sys_int_o <= 1'b0;
        end else begin
            syncA     <= irq_i;
            syncB     <= syncA;
            edgeHist  <= syncB;
            isr       <= isrNext;
            ier       <= ierNext;
            imr       <= imrNext;
            mer       <= merNext;
            dwb_ack_o <= accept;
            dwb_dat_o <= accept ? readMux : '0;
            sys_int_o <= mer & (|active);
        end
    end

endmodule

// File: tb/tb_aemb_intc.sv
// Directed bench for aemb_intc: register reads are checked through an expectation queue
// filled when each access is issued and drained when the ack returns.
module tb_aemb_intc;

    logic        clk;
    logic        rstN;
    logic [7:0]  irq;
    logic        dwbStb;
    logic        dwbWre;
    logic [2:0]  dwbAdr;
    logic [31:0] dwbDatIn;
    logic [31:0] dwbDatOut;
    logic        dwbAck;
    logic        sysInt;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] expQ[$];
    string       tagQ[$];
    logic [31:0] rdData;
    logic        ackSeen;
    int          ackCount;
    logic [31:0] expVal;
    string       expTag;

    aemb_intc #(.NCH(8), .DW(32)) dut (
        .sys_clk_i (clk),
        .sys_rst_i (rstN),
        .irq_i     (irq),
        .dwb_stb_i (dwbStb),
        .dwb_wre_i (dwbWre),
        .dwb_adr_i (dwbAdr),
        .dwb_dat_i (dwbDatIn),
        .dwb_dat_o (dwbDatOut),
        .dwb_ack_o (dwbAck),
        .sys_int_o (sysInt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One single-beat access; returns just after the acking edge.
    task automatic applyStimulus(input logic wre, input logic [2:0] adr, input logic [31:0] dat,
                                 output logic [31:0] rd, output logic ack);
        @(negedge clk);
        if (dwbAck) @(negedge clk);
        dwbStb   = 1'b1;
        dwbWre   = wre;
        dwbAdr   = adr;
        dwbDatIn = dat;
        @(posedge clk);
        #1;
        ack    = dwbAck;
        rd     = dwbDatOut;
        dwbStb = 1'b0;
        dwbWre = 1'b0;
    endtask

    task automatic writeReg(input logic [2:0] adr, input logic [31:0] dat, input string tag);
        logic [31:0] rd;
        logic        ack;
        applyStimulus(1'b1, adr, dat, rd, ack);
        checkOutput({tag, "-ack"}, 32'(ack), 32'd1);
    endtask

    task automatic readCheck(input logic [2:0] adr, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        logic        ack;
        expQ.push_back(exp);
        tagQ.push_back(tag);
        applyStimulus(1'b0, adr, 32'h0, rd, ack);
        expVal = expQ.pop_front();
        expTag = tagQ.pop_front();
        checkOutput({expTag, "-ack"}, 32'(ack), 32'd1);
        checkOutput(expTag, rd, expVal);
    endtask

    initial begin
        rstN = 1'b1; irq = '0; dwbStb = 1'b0; dwbWre = 1'b0; dwbAdr = '0; dwbDatIn = '0;
        #2 rstN = 1'b0;
        #1;
        checkOutput("rst-ack", 32'(dwbAck), 32'd0);
        checkOutput("rst-dat", dwbDatOut, 32'd0);
        checkOutput("rst-int", 32'(sysInt), 32'd0);
        @(negedge clk); rstN = 1'b1;
        readCheck(3'd0, 32'h0, "rst-isr");
        readCheck(3'd1, 32'h0, "rst-ier");
        readCheck(3'd5, 32'hFFFF_FFFF, "rst-ivr");
        readCheck(3'd7, 32'h0, "rst-imr");

        // Edge-mode pulse on channel 2, then acknowledge it.
        writeReg(3'd7, 32'hFF, "imr");
        writeReg(3'd1, 32'h05, "ier");
        writeReg(3'd6, 32'h1, "mer");
        readCheck(3'd6, 32'h1, "mer-rd");
        @(negedge clk); irq = 8'h04;
        repeat (3) @(negedge clk);
        irq = 8'h00;
        @(negedge clk);
        checkOutput("edge-int", 32'(sysInt), 32'd1);
        readCheck(3'd0, 32'h04, "edge-isr");
        readCheck(3'd5, 32'h2, "edge-ivr");
        writeReg(3'd2, 32'h04, "iar");
        checkOutput("iar-int-lag", 32'(sysInt), 32'd1);
        @(posedge clk); #1;
        checkOutput("iar-int", 32'(sysInt), 32'd0);
        readCheck(3'd0, 32'h0, "iar-isr");
        readCheck(3'd2, 32'h0, "iar-rd0");

        // Level mode: IAR cannot clear a still-high source.
        writeReg(3'd7, 32'h00, "imr-lvl");
        @(negedge clk); irq = 8'h01;
        repeat (4) @(posedge clk);
        readCheck(3'd0, 32'h01, "lvl-isr");
        writeReg(3'd2, 32'h01, "lvl-iar");
        readCheck(3'd0, 32'h01, "lvl-isr-hold");
        checkOutput("lvl-int", 32'(sysInt), 32'd1);
        @(negedge clk); irq = 8'h00;
        repeat (3) @(posedge clk);
        readCheck(3'd0, 32'h0, "lvl-isr-drop");
        checkOutput("lvl-int-drop", 32'(sysInt), 32'd0);

        // Pending captures while disabled; SIE/CIE gate the request.
        writeReg(3'd1, 32'h0, "ier-0");
        writeReg(3'd7, 32'hFF, "imr-edge");
        @(negedge clk); irq = 8'h20;
        repeat (4) @(posedge clk);
        readCheck(3'd0, 32'h20, "dis-isr");
        checkOutput("dis-int", 32'(sysInt), 32'd0);
        writeReg(3'd3, 32'h20, "sie");
        @(posedge clk); #1;
        checkOutput("sie-int", 32'(sysInt), 32'd1);
        readCheck(3'd1, 32'h20, "sie-ier");
        readCheck(3'd3, 32'h0, "sie-rd0");
        readCheck(3'd5, 32'h5, "sie-ivr");
        writeReg(3'd4, 32'h20, "cie");
        @(posedge clk); #1;
        checkOutput("cie-int", 32'(sysInt), 32'd0);
        readCheck(3'd1, 32'h0, "cie-ier");
        irq = 8'h00;
        writeReg(3'd0, 32'h20, "isr-w1c");
        readCheck(3'd0, 32'h0, "isr-w1c-rd");

        // Rise on channel 3 coincides with the IAR ack edge: set must win.
        @(negedge clk); irq = 8'h08;
        repeat (2) @(posedge clk);
        writeReg(3'd2, 32'h08, "race-iar");
        readCheck(3'd0, 32'h08, "race-isr");
        irq = 8'h00;
        writeReg(3'd2, 32'h08, "race-clr");
        readCheck(3'd0, 32'h0, "race-isr-clr");

        // Width masking and a held strobe.
        writeReg(3'd1, 32'hFFFF_FFFF, "ier-wide");
        readCheck(3'd1, 32'hFF, "ier-mask");
        readCheck(3'd5, 32'hFFFF_FFFF, "ivr-none");
        for (int k = 0; k < 6; k++) expQ.push_back((k % 2 == 0) ? 32'hFF : 32'h0);
        @(negedge clk);
        if (dwbAck) @(negedge clk);
        dwbStb = 1'b1; dwbWre = 1'b0; dwbAdr = 3'd1;
        ackCount = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (dwbAck) ackCount++;
            expVal = expQ.pop_front();
            checkOutput("held-ack", 32'(dwbAck), (k % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput("held-dat", dwbDatOut, expVal);
        end
        dwbStb = 1'b0;
        checkOutput("held-count", 32'(ackCount), 32'd3);

        // Two pending channels, priority, then reset in the middle of a read.
        @(negedge clk); irq = 8'h81;
        repeat (3) @(posedge clk);
        irq = 8'h00;
        repeat (2) @(posedge clk);
        readCheck(3'd0, 32'h81, "pre-isr");
        readCheck(3'd5, 32'h0, "pre-ivr0");
        checkOutput("pre-int", 32'(sysInt), 32'd1);
        writeReg(3'd4, 32'h01, "pre-cie");
        readCheck(3'd5, 32'h7, "pre-ivr7");
        @(negedge clk);
        if (dwbAck) @(negedge clk);
        dwbStb = 1'b1; dwbWre = 1'b0; dwbAdr = 3'd0;
        @(posedge clk); #1;
        checkOutput("mid-ack", 32'(dwbAck), 32'd1);
        checkOutput("mid-dat", dwbDatOut, 32'h81);
        #2 rstN = 1'b0;
        #1;
        checkOutput("mid-rst-ack", 32'(dwbAck), 32'd0);
        checkOutput("mid-rst-dat", dwbDatOut, 32'd0);
        checkOutput("mid-rst-int", 32'(sysInt), 32'd0);
        dwbStb = 1'b0;
        @(negedge clk); rstN = 1'b1;
        readCheck(3'd0, 32'h0, "post-isr");
        readCheck(3'd1, 32'h0, "post-ier");
        readCheck(3'd6, 32'h0, "post-mer");
        readCheck(3'd5, 32'hFFFF_FFFF, "post-ivr");
        checkOutput("post-int", 32'(sysInt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aemb_intc.md
AEMB_INTC -- requirements
Module: aemb_intc

Interface
REQ-001 The block SHALL have parameter NCH, default 8, giving the number of interrupt channels; legal range 1..32.
REQ-002 The block SHALL have parameter DW, default 32, giving the data-bus width; only 32 is supported.
REQ-003 The block SHALL have port sys_clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port sys_rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port irq_i, input, NCH bits: asynchronous interrupt sources, one per channel.
REQ-006 The block SHALL have port dwb_stb_i, input, 1 bit: Wishbone slave strobe.
REQ-007 The block SHALL have port dwb_wre_i, input, 1 bit: write enable, 1 = write.
REQ-008 The block SHALL have port dwb_adr_i, input, 3 bits: word address of the register, byte address bits [4:2].
REQ-009 The block SHALL have port dwb_dat_i, input, 32 bits: write data.
REQ-010 The block SHALL have port dwb_dat_o, output, 32 bits: read data, valid while dwb_ack_o=1.
REQ-011 The block SHALL have port dwb_ack_o, output, 1 bit: transfer acknowledge.
REQ-012 The block SHALL have port sys_int_o, output, 1 bit: aggregated interrupt request to the core's sys_int_i.

Function
REQ-013 Register map: 0 ISR pending (R; W1C alias of IAR); 1 IER enable (R/W); 2 IAR acknowledge (W1C, reads 0); 3 SIE set-enable (W1S, reads 0); 4 CIE clear-enable (W1C, reads 0); 5 IVR vector (R); 6 MER master enable, bit0 (R/W); 7 IMR mode, 1 = edge, 0 = level (R/W).
REQ-014 Register bits at or above NCH SHALL read 0 and ignore writes; MER bits [31:1] SHALL read 0.
REQ-015 Each irq_i bit SHALL pass through a 2-flop synchroniser before use.
REQ-016 Edge mode: the pending bit SHALL set on the cycle after the synchronised input goes 0->1 and SHALL hold until cleared via IAR/ISR.
REQ-017 Level mode: the pending bit SHALL equal the synchronised input, registered; IAR writes SHALL have no lasting effect while the input is high.
REQ-018 Pending latency: an irq_i rise stable for 3 clocks SHALL appear in ISR by the 4th rising edge.
REQ-019 sys_int_o SHALL be registered and equal MER[0] & |(ISR & IER), one cycle after ISR/IER/MER change.
REQ-020 If a set event and an IAR clear hit the same bit in the same cycle, set SHALL win and the bit stays 1.
REQ-021 A simultaneous SIE and CIE on one bit cannot occur, because there is one write per access.
REQ-022 Pending SHALL capture regardless of IER; enabling a channel later SHALL raise sys_int_o if pending is still set.
REQ-023 IVR SHALL read the index of the lowest-numbered bit in ISR & IER (channel 0 highest priority), or 0xFFFFFFFF if none; MER does not affect IVR.
REQ-024 Bus handshake: dwb_ack_o SHALL be registered as dwb_stb_i & ~dwb_ack_o, so a held strobe yields one ack every 2 cycles.
REQ-025 Register writes SHALL take effect on the edge where dwb_ack_o rises; each access SHALL cause exactly one effect.
REQ-026 dwb_dat_o SHALL be registered with the ack and SHALL be 0 when dwb_ack_o=0.
REQ-027 Changing IMR from edge to level SHALL leave pending bits as they are; level tracking SHALL resume from the next cycle.

Reset
REQ-028 Reset SHALL act asynchronously on sys_rst_i=0, including mid-access: ISR, IER, MER, IMR, synchronisers, edge history, dwb_ack_o, dwb_dat_o and sys_int_o all clear to 0, and IVR reads 0xFFFFFFFF.
REQ-029 Deassertion SHALL be synchronised externally; the first edge after sys_rst_i=1 SHALL be able to accept a bus access.
REQ-030 An irq_i already high when reset deasserts SHALL NOT create an edge-mode pending bit, because edge history resets to 0 and edge mode is off by default.

Verification
REQ-031 NCH=8: IMR=0xFF, IER=0x05, MER=1, then pulse irq_i[2] high for 3 clocks -> ISR=0x04, sys_int_o=1, IVR=2; write IAR=0x04 -> ISR=0, sys_int_o=0 one cycle later.
REQ-032 Level mode with irq_i[0] held high: write IAR=0x01 -> ISR[0] still 1; drop irq_i -> ISR[0]=0 within 3 cycles.
REQ-033 Edge mode, IER=0, irq_i[5] rises: ISR=0x20 and sys_int_o=0; then SIE=0x20 -> sys_int_o=1; then CIE=0x20 -> IER=0, sys_int_o=0.
REQ-034 Synchronised rise of channel 3 landing on the same edge as the IAR=0x08 write ack -> ISR[3]=1.
REQ-035 dwb_stb_i held high for 6 cycles on a read -> exactly 3 ack pulses, with dwb_dat_o=0 between them; IER=0xFFFFFFFF write with NCH=8 -> IER reads 0xFF.
REQ-036 sys_rst_i pulsed low mid-transfer with ISR=0x81 -> all outputs 0 immediately and IVR=0xFFFFFFFF after release.
